// File: rtl/imem_refill_responder.sv
// rtl/imem_refill_responder.sv - icache line-refill responder with preloadable word RAM
// Optional macro IMEM_RESP_CRITICAL_WORD_FIRST_EN: burst starts at the requested word, wrapping in the line.
module imem_refill_responder #(
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    output logic                  mem_valid_o,
    output logic [WORD_WIDTH-1:0] mem_inst_o,
    output logic                  busy_o,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [WORD_WIDTH-1:0] ld_data_i
);
    localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
    localparam int B_BITS = $clog2(BEATS);
    localparam int W_BITS = $clog2(MEM_WORDS);
    localparam int L_BITS = W_BITS - B_BITS;
    localparam logic [7:0] LAT_LOAD = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);
    localparam logic [B_BITS-1:0] LAST_BEAT = B_BITS'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_RELEASE} state_t;

    state_t              r_state;
    logic [L_BITS-1:0]   r_line;
    logic [B_BITS-1:0]   r_start;
    logic [B_BITS-1:0]   r_beat;
    logic [7:0]          r_cnt;
    logic [WORD_WIDTH-1:0] r_ram [MEM_WORDS];

    logic [L_BITS-1:0]   w_req_line;
    logic [B_BITS-1:0]   w_req_off;
    logic [B_BITS-1:0]   w_rd_off;
    logic [W_BITS-1:0]   w_rd_idx;
    logic [W_BITS-1:0]   w_ld_idx;

    // Upper address bits beyond the RAM depth are dropped, so addresses alias.
    assign w_req_line = mem_addr_i[2+B_BITS +: L_BITS];
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
    assign w_req_off  = mem_addr_i[2 +: B_BITS];
`else
    assign w_req_off  = '0;
`endif
    assign w_rd_off   = r_start + r_beat;
    assign w_rd_idx   = {r_line, w_rd_off};
    assign w_ld_idx   = ld_addr_i[2 +: W_BITS];
    assign busy_o     = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            r_ram[w_ld_idx] <= ld_data_i;
        end
    end

    // The burst read samples the RAM array in this block, so a same-edge preload sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_line      <= '0;
            r_start     <= '0;
            r_beat      <= '0;
            r_cnt       <= '0;
            mem_valid_o <= 1'b0;
            mem_inst_o  <= '0;
        end else begin
            mem_valid_o <= 1'b0;
            mem_inst_o  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        r_line  <= w_req_line;
                        r_start <= w_req_off;
                        r_beat  <= '0;
                        r_cnt   <= LAT_LOAD;
                        r_state <= (LATENCY == 0) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_BURST;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_BURST: begin
                    mem_valid_o <= 1'b1;
                    mem_inst_o  <= r_ram[w_rd_idx];
                    if (r_beat == LAST_BEAT) begin
                        r_beat  <= '0;
                        r_state <= S_RELEASE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!mem_req_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_refill_responder.sv
// tb/tb_imem_refill_responder.sv - directed self-checking bench for imem_refill_responder
module tb_imem_refill_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_i;
    logic [31:0] mem_addr_i;
    logic        mem_valid_o;
    logic [31:0] mem_inst_o;
    logic        busy_o;
    logic        ld_we_i;
    logic [31:0] ld_addr_i;
    logic [31:0] ld_data_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_refill_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req_i  (mem_req_i),
        .mem_addr_i (mem_addr_i),
        .mem_valid_o(mem_valid_o),
        .mem_inst_o (mem_inst_o),
        .busy_o     (busy_o),
        .ld_we_i    (ld_we_i),
        .ld_addr_i  (ld_addr_i),
        .ld_data_i  (ld_data_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp [4];
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        ld_we_i   = 1'b1;
        ld_addr_i = addr;
        ld_data_i = data;
        tick();
        ld_we_i   = 1'b0;
    endtask

    // Accept edge, then count cycles until the first beat (bounded).
    task automatic start_req(input logic [31:0] addr);
        int cyc;
        mem_addr_i = addr;
        mem_req_i  = 1'b1;
        tick();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!mem_valid_o && cyc < 40);
        check("first_beat_latency", cyc, 5);
    endtask

    task automatic run_req(input logic [31:0] addr, output logic [31:0] got [4]);
        start_req(addr);
        got[0] = mem_inst_o;
        for (int b = 1; b < 4; b++) begin
            tick();
            check("beat_valid", {31'd0, mem_valid_o}, 32'd1);
            got[b] = mem_inst_o;
        end
    endtask

    task automatic release_req;
        mem_req_i = 1'b0;
        tick();
        check("release_busy", {31'd0, busy_o}, 32'd0);
        check("release_valid", {31'd0, mem_valid_o}, 32'd0);
        check("release_inst", mem_inst_o, 32'd0);
    endtask

    vec_t vecs [5];
    logic [31:0] got [4];

    initial begin
        vecs[0].addr = 32'h0000_0100;
        vecs[0].exp  = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        vecs[1].addr = 32'h0000_0108;
        vecs[2].addr = 32'h0000_011C;
        vecs[3].addr = 32'h0000_4004;
        vecs[4].addr = 32'hFFFF_0104;
`ifdef IMEM_RESP_CRITICAL_WORD_FIRST_EN
        vecs[1].exp  = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0000, 32'hA000_0001};
        vecs[2].exp  = '{32'hB000_0003, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002};
        vecs[3].exp  = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0000};
        vecs[4].exp  = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0000};
`else
        vecs[1].exp  = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        vecs[2].exp  = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
        vecs[3].exp  = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
        vecs[4].exp  = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
`endif

        rst_n      = 1'b0;
        mem_req_i  = 1'b1;
        mem_addr_i = 32'h0000_0100;
        ld_we_i    = 1'b0;
        ld_addr_i  = '0;
        ld_data_i  = '0;
        tick();
        tick();
        check("reset_valid", {31'd0, mem_valid_o}, 32'd0);
        check("reset_inst", mem_inst_o, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        mem_req_i = 1'b0;
        rst_n     = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            preload(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            preload(32'h110 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            preload(32'h000 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        end

        for (int v = 0; v < 5; v++) begin
            run_req(vecs[v].addr, got);
            for (int b = 0; b < 4; b++) begin
                check($sformatf("vec%0d_beat%0d", v, b), got[b], vecs[v].exp[b]);
            end
            release_req();
        end

        // Request held after the burst must not be serviced again.
        run_req(32'h100, got);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("held_no_valid", {31'd0, mem_valid_o}, 32'd0);
            check("held_busy", {31'd0, busy_o}, 32'd1);
        end
        release_req();
        run_req(32'h100, got);
        check("rereq_beat3", got[3], 32'hA000_0003);
        release_req();

        // Preload of the word being read on the same edge returns old data.
        start_req(32'h100);
        check("rbw_beat0", mem_inst_o, 32'hA000_0000);
        ld_we_i   = 1'b1;
        ld_addr_i = 32'h104;
        ld_data_i = 32'h0000_DEAD;
        tick();
        ld_we_i   = 1'b0;
        check("rbw_old_value", mem_inst_o, 32'hA000_0001);
        tick();
        tick();
        release_req();
        run_req(32'h100, got);
        check("rbw_new_value", got[1], 32'h0000_DEAD);
        release_req();

        preload(32'h4000, 32'h0000_1234);
        run_req(32'h0, got);
        check("alias_word0", got[0], 32'h0000_1234);
        release_req();

        // Reset in the middle of a burst.
        start_req(32'h100);
        tick();
        tick();
        check("mid_beat2", mem_inst_o, 32'hA000_0002);
        rst_n     = 1'b0;
        mem_req_i = 1'b0;
        #1;
        check("midrst_valid", {31'd0, mem_valid_o}, 32'd0);
        check("midrst_inst", mem_inst_o, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_idle", {31'd0, busy_o}, 32'd0);
        run_req(32'h100, got);
        check("postrst_beat0", got[0], 32'hA000_0000);
        check("postrst_beat1", got[1], 32'h0000_DEAD);
        check("postrst_beat2", got[2], 32'hA000_0002);
        check("postrst_beat3", got[3], 32'hA000_0003);
        release_req();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
